// File: rtl/shared_mul_gf2_arb.sv
// Round-robin front end for one shared, pipelined DOM GF(2^2) multiplier.
// Each issue consumes one randomness word and carries a requester tag through to the response.
module shared_mul_gf2_arb #(
  parameter int SHARES  = 3,
  parameter int NREQ    = 4,
  parameter int LATENCY = 1,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                          ClkxCI,
  input  logic                          RstxRI,
  input  logic [NREQ-1:0]               ReqValidxSI,
  output logic [NREQ-1:0]               ReqReadyxSO,
  input  logic [NREQ*2*SHARES-1:0]      ReqXxDI,
  input  logic [NREQ*2*SHARES-1:0]      ReqYxDI,
  input  logic                          RndValidxSI,
  output logic                          RndReadyxSO,
  input  logic [SHARES*(SHARES-1)-1:0]  RndxDI,
  output logic [2*SHARES-1:0]           MulXxDO,
  output logic [2*SHARES-1:0]           MulYxDO,
  output logic [SHARES*(SHARES-1)-1:0]  MulZxDO,
  input  logic [2*SHARES-1:0]           MulQxDI,
  output logic                          RspValidxSO,
  output logic [IDW-1:0]                RspIdxDO,
  output logic [2*SHARES-1:0]           RspQxDO,
  output logic                          BusyxSO
);
  localparam int EW    = 2 * SHARES;
  localparam int ZW    = SHARES * (SHARES - 1);
  localparam int DEPTH = 1 + LATENCY;

  // Handshake: a requester is served in the cycle its ReqReadyxSO bit is high; the same
  // cycle RndReadyxSO pops one randomness word. Responses have no backpressure.
  logic [IDW-1:0]           ptr_q, ptr_d;
  logic [IDW-1:0]           gnt_idx;
  logic [IDW:0]             scan_idx;
  logic                     found;
  logic                     issue;
  logic [EW-1:0]            mul_x_q, mul_x_d;
  logic [EW-1:0]            mul_y_q, mul_y_d;
  logic [ZW-1:0]            mul_z_q, mul_z_d;
  logic [DEPTH-1:0]         vld_q;
  logic [DEPTH-1:0][IDW-1:0] tag_q;

  // Scan upward from the pointer, wrapping at NREQ, and keep the first hit.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NREQ)) scan_idx = scan_idx - (IDW+1)'(NREQ);
      if (!found && ReqValidxSI[scan_idx[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = scan_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    issue       = !RstxRI && RndValidxSI && found;
    ReqReadyxSO = issue ? (NREQ'(1) << gnt_idx) : '0;
    RndReadyxSO = issue;
    ptr_d       = ptr_q;
    mul_x_d     = '0;
    mul_y_d     = '0;
    mul_z_d     = '0;
    if (issue) begin
      ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      mul_x_d = ReqXxDI[gnt_idx*EW +: EW];
      mul_y_d = ReqYxDI[gnt_idx*EW +: EW];
      mul_z_d = RndxDI;
    end
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      ptr_q   <= '0;
      mul_x_q <= '0;
      mul_y_q <= '0;
      mul_z_q <= '0;
      vld_q   <= '0;
      tag_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      mul_x_q  <= mul_x_d;
      mul_y_q  <= mul_y_d;
      mul_z_q  <= mul_z_d;
      vld_q[0] <= issue;
      tag_q[0] <= issue ? gnt_idx : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign MulXxDO     = mul_x_q;
  assign MulYxDO     = mul_y_q;
  assign MulZxDO     = mul_z_q;
  assign RspValidxSO = vld_q[DEPTH-1];
  assign RspIdxDO    = tag_q[DEPTH-1];
  assign RspQxDO     = MulQxDI;
  assign BusyxSO     = |vld_q;
endmodule
